// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_generator
//  Purpose  : Per-channel PWM output stage with double-buffered edge sets;
//             updates take effect only at a period boundary.
//  Options  : PWM_SYNC_EN adds a SYNC input that restarts every counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_generator #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             UPDATE,
`ifdef PWM_SYNC_EN
    input  logic             SYNC,
`endif
    input  logic [WIDTH-1:0] CYCLE [DEPTH],
    input  logic [DEPTH-1:0] OVER,
    input  logic [WIDTH-1:0] LEFT  [DEPTH],
    input  logic [WIDTH-1:0] RIGHT [DEPTH],
    output logic [DEPTH-1:0] PWM_OUT
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic w_sync;
`ifdef PWM_SYNC_EN
    assign w_sync = SYNC;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_chan
        logic [WIDTH-1:0] r_t;
        logic [WIDTH-1:0] r_cyc;
        logic [WIDTH-1:0] r_left;
        logic [WIDTH-1:0] r_right;
        logic             r_over;
        logic [WIDTH-1:0] r_sh_cyc;
        logic [WIDTH-1:0] r_sh_left;
        logic [WIDTH-1:0] r_sh_right;
        logic             r_sh_over;
        logic             r_pending;
        logic             r_out;

        logic w_short;
        logic w_wrap;
        logic w_bound;
        logic w_load;
        logic w_hi;

        // A period shorter than two ticks parks the counter and lets a
        // pending shadow load on the very next clock.
        assign w_short = (r_cyc[WIDTH-1:1] == '0);
        assign w_wrap  = (r_t == (r_cyc - c_one));
        assign w_bound = w_short | w_wrap | w_sync;
        assign w_load  = w_bound & r_pending;
        assign w_hi    = r_over ? ((r_t < r_right) | (r_left <= r_t))
                                : ((r_left <= r_t) & (r_t < r_right));

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_t        <= '0;
                r_cyc      <= '0;
                r_left     <= '0;
                r_right    <= '0;
                r_over     <= 1'b0;
                r_sh_cyc   <= '0;
                r_sh_left  <= '0;
                r_sh_right <= '0;
                r_sh_over  <= 1'b0;
                r_pending  <= 1'b0;
                r_out      <= 1'b0;
            end else begin
                // A fresh capture keeps pending set even if the boundary
                // consumes the previous shadow on this same clock.
                if (UPDATE) begin
                    r_sh_cyc   <= CYCLE[i];
                    r_sh_left  <= LEFT[i];
                    r_sh_right <= RIGHT[i];
                    r_sh_over  <= OVER[i];
                    r_pending  <= 1'b1;
                end else if (w_load) begin
                    r_pending  <= 1'b0;
                end

                if (w_load) begin
                    r_cyc   <= r_sh_cyc;
                    r_left  <= r_sh_left;
                    r_right <= r_sh_right;
                    r_over  <= r_sh_over;
                end

                if (w_bound) begin
                    r_t <= '0;
                end else begin
                    r_t <= r_t + c_one;
                end

                r_out <= w_hi & ~w_short;
            end
        end

        assign PWM_OUT[i] = r_out;
    end

endmodule
`default_nettype wire
